// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core: key codes, ALU op encoding,
// FSM state encoding and small key-classification helpers.
package calc_pkg;

  localparam logic [4:0] KEY_AC  = 5'h10;
  localparam logic [4:0] KEY_ADD = 5'h11;
  localparam logic [4:0] KEY_SUB = 5'h12;
  localparam logic [4:0] KEY_MUL = 5'h13;
  localparam logic [4:0] KEY_DIV = 5'h14;
  localparam logic [4:0] KEY_EQ  = 5'h15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_OP_WAIT = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Codes 0x00-0x0F are hex digits.
  function automatic logic is_digit(input logic [4:0] key);
    return (key[4] == 1'b0);
  endfunction

  // ADD, SUB, MUL and DIV occupy a contiguous block of codes.
  function automatic logic is_operator(input logic [4:0] key);
    return (key >= KEY_ADD) && (key <= KEY_DIV);
  endfunction

  function automatic alu_op_e key_to_op(input logic [4:0] key);
    alu_op_e op;
    case (key)
      KEY_ADD: op = OP_ADD;
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_operand_reg.sv
// Hex operand register: shifts digits in from the right and tracks how many
// digits have been entered. Clear beats load, load beats shift; a shift while
// full is dropped so the caller can treat that digit as ignored.
module calc_operand_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_load_full,
  input  logic             i_shift,
  input  logic [3:0]       i_digit,
  output logic [WIDTH-1:0] o_value,
  output logic [WIDTH-1:0] o_shifted,
  output logic             o_full
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_value;
  logic [CW-1:0]    r_count;

  assign o_value   = r_value;
  assign o_shifted = (r_value << 4) | WIDTH'(i_digit);
  assign o_full    = (r_count == CNT_MAX);

  // Operand value and digit count update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
      r_count <= i_load_full ? CNT_MAX : CNT_ONE;
    end else if (i_shift && !o_full) begin
      r_value <= o_shifted;
      r_count <= r_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/calc_core.sv
// Calculator control FSM: accepts key codes, builds operands A and B,
// sequences ALU operations and pushes every display update to the driver.
module calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_alu_start,
  output logic [1:0]       o_alu_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic             i_alu_done,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_error,
  output logic [WIDTH-1:0] o_disp_data,
  output logic             o_disp_error,
  output logic             o_disp_valid,
  input  logic             i_disp_ready
);

  state_e           r_state, w_state_nxt;
  alu_op_e          r_op, w_op_nxt;
  alu_op_e          r_pend_op, w_pend_op_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_alu_start, w_alu_start_nxt;
  logic [WIDTH-1:0] r_disp_data, w_disp_data_nxt;
  logic             r_disp_err, w_disp_err_nxt;
  logic             r_disp_valid, w_disp_valid_nxt;

  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic             w_push_err;

  logic             w_a_clear, w_a_load, w_a_load_full, w_a_shift, w_a_full;
  logic [WIDTH-1:0] w_a_load_val, w_a_value, w_a_shifted;
  logic             w_b_clear, w_b_load, w_b_shift, w_b_full;
  logic [WIDTH-1:0] w_b_value, w_b_shifted;

  logic             w_key_acc;
  logic             w_alu_done;
  logic [WIDTH-1:0] w_digit_val;

  assign o_ready     = (r_state != ST_EXEC) && !r_disp_valid;
  assign w_key_acc   = i_valid && o_ready;
  // The cycle carrying the start pulse is not a valid completion slot.
  assign w_alu_done  = i_alu_done && (r_state == ST_EXEC) && !r_alu_start;
  assign w_digit_val = WIDTH'(i_data[3:0]);

  assign o_alu_start  = r_alu_start;
  assign o_alu_op     = r_op;
  assign o_alu_a      = w_a_value;
  assign o_alu_b      = w_b_value;
  assign o_disp_data  = r_disp_data;
  assign o_disp_error = r_disp_err;
  assign o_disp_valid = r_disp_valid;

  calc_operand_reg #(.WIDTH(WIDTH)) u_opnd_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_a_clear),
    .i_load      (w_a_load),
    .i_load_val  (w_a_load_val),
    .i_load_full (w_a_load_full),
    .i_shift     (w_a_shift),
    .i_digit     (i_data[3:0]),
    .o_value     (w_a_value),
    .o_shifted   (w_a_shifted),
    .o_full      (w_a_full)
  );

  calc_operand_reg #(.WIDTH(WIDTH)) u_opnd_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_b_clear),
    .i_load      (w_b_load),
    .i_load_val  (w_digit_val),
    .i_load_full (1'b0),
    .i_shift     (w_b_shift),
    .i_digit     (i_data[3:0]),
    .o_value     (w_b_value),
    .o_shifted   (w_b_shifted),
    .o_full      (w_b_full)
  );

  // State and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ENTER_A;
      r_op         <= OP_ADD;
      r_pend_op    <= OP_ADD;
      r_pend       <= 1'b0;
      r_alu_start  <= 1'b0;
      r_disp_data  <= '0;
      r_disp_err   <= 1'b0;
      r_disp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_pend_op    <= w_pend_op_nxt;
      r_pend       <= w_pend_nxt;
      r_alu_start  <= w_alu_start_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_err   <= w_disp_err_nxt;
      r_disp_valid <= w_disp_valid_nxt;
    end
  end

  // Next-state, operand controls and display/ALU handshake decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_pend_op_nxt    = r_pend_op;
    w_pend_nxt       = r_pend;
    w_alu_start_nxt  = 1'b0;
    w_disp_valid_nxt = r_disp_valid && !i_disp_ready;
    w_disp_data_nxt  = r_disp_data;
    w_disp_err_nxt   = r_disp_err;
    w_push           = 1'b0;
    w_push_data      = '0;
    w_push_err       = 1'b0;
    w_a_clear        = 1'b0;
    w_a_load         = 1'b0;
    w_a_load_val     = i_alu_result;
    w_a_load_full    = 1'b0;
    w_a_shift        = 1'b0;
    w_b_clear        = 1'b0;
    w_b_load         = 1'b0;
    w_b_shift        = 1'b0;

    if (w_key_acc) begin
      if (i_data == KEY_AC) begin
        w_a_clear   = 1'b1;
        w_b_clear   = 1'b1;
        w_op_nxt    = OP_ADD;
        w_pend_nxt  = 1'b0;
        w_state_nxt = ST_ENTER_A;
        w_push      = 1'b1;
      end else if (is_digit(i_data)) begin
        case (r_state)
          ST_ENTER_A: begin
            if (!w_a_full) begin
              w_a_shift   = 1'b1;
              w_push      = 1'b1;
              w_push_data = w_a_shifted;
            end else begin
              w_push = 1'b0;
            end
          end
          ST_OP_WAIT: begin
            w_b_load    = 1'b1;
            w_state_nxt = ST_ENTER_B;
            w_push      = 1'b1;
            w_push_data = w_digit_val;
          end
          ST_ENTER_B: begin
            if (!w_b_full) begin
              w_b_shift   = 1'b1;
              w_push      = 1'b1;
              w_push_data = w_b_shifted;
            end else begin
              w_push = 1'b0;
            end
          end
          ST_RESULT: begin
            w_a_load     = 1'b1;
            w_a_load_val = w_digit_val;
            w_state_nxt  = ST_ENTER_A;
            w_push       = 1'b1;
            w_push_data  = w_digit_val;
          end
          default: begin
            w_push = 1'b0;
          end
        endcase
      end else if (is_operator(i_data)) begin
        case (r_state)
          ST_ENTER_A, ST_OP_WAIT, ST_RESULT: begin
            w_op_nxt    = key_to_op(i_data);
            w_state_nxt = ST_OP_WAIT;
            w_push      = 1'b1;
            w_push_data = w_a_value;
          end
          ST_ENTER_B: begin
            // Chained operator: run the latched op now, apply this one after.
            w_pend_nxt      = 1'b1;
            w_pend_op_nxt   = key_to_op(i_data);
            w_state_nxt     = ST_EXEC;
            w_alu_start_nxt = 1'b1;
          end
          default: begin
            w_push = 1'b0;
          end
        endcase
      end else if ((i_data == KEY_EQ) && (r_state == ST_ENTER_B)) begin
        w_pend_nxt      = 1'b0;
        w_state_nxt     = ST_EXEC;
        w_alu_start_nxt = 1'b1;
      end else begin
        w_push = 1'b0;
      end
    end else if (w_alu_done) begin
      w_push = 1'b1;
      if (i_alu_error) begin
        w_push_err  = 1'b1;
        w_state_nxt = ST_ERROR;
      end else begin
        w_a_load      = 1'b1;
        w_a_load_full = 1'b1;
        w_push_data   = i_alu_result;
        if (r_pend) begin
          w_op_nxt    = r_pend_op;
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_OP_WAIT;
        end else begin
          w_state_nxt = ST_RESULT;
        end
      end
    end else begin
      w_push = 1'b0;
    end

    if (w_push) begin
      w_disp_valid_nxt = 1'b1;
      w_disp_data_nxt  = w_push_data;
      w_disp_err_nxt   = w_push_err;
    end else begin
      w_disp_err_nxt = r_disp_err;
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: fixed key-sequence table, hand-written
// backpressure and reset corner cases, then randomized keys against a
// behavioural calculator model.
module tb_calc_core;
  import calc_pkg::*;

  localparam int W = 16;
  localparam logic [4:0] PAD = 5'h16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    i_data = 5'h00;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          o_alu_start;
  logic [1:0]    o_alu_op;
  logic [W-1:0]  o_alu_a, o_alu_b;
  logic          i_alu_done = 1'b0;
  logic [W-1:0]  i_alu_result = '0;
  logic          i_alu_error = 1'b0;
  logic [W-1:0]  o_disp_data;
  logic          o_disp_error;
  logic          o_disp_valid;
  logic          i_disp_ready = 1'b1;

  always #5 clk = ~clk;

  calc_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_alu_start(o_alu_start), .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_done(i_alu_done), .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
    .o_disp_data(o_disp_data), .o_disp_error(o_disp_error), .o_disp_valid(o_disp_valid),
    .i_disp_ready(i_disp_ready)
  );

  typedef struct packed { logic [15:0] data; logic err; } disp_t;
  typedef struct packed { logic [1:0] op; logic [15:0] a; logic [15:0] b; } start_t;

  disp_t  got_disp[$], exp_disp[$];
  start_t got_start[$], exp_start[$];

  int total = 0;
  int bad   = 0;
  bit rnd_rdy = 1'b0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic of the ALU: 16-bit wrap, divide by zero flagged.
  task automatic alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic err);
    logic [31:0] full;
    err = 1'b0;
    case (op)
      2'd0: full = {16'd0, a} + {16'd0, b};
      2'd1: full = {16'd0, a} - {16'd0, b};
      2'd2: full = {16'd0, a} * {16'd0, b};
      default: begin
        if (b == 16'd0) begin err = 1'b1; full = 32'd0; end
        else full = {16'd0, a / b};
      end
    endcase
    res = full[15:0];
  endtask

  // ALU with 3-cycle latency, plus monitors for starts and display transfers.
  int          alu_cnt = 0;
  logic [1:0]  alu_op_q;
  logic [15:0] alu_a_q, alu_b_q;
  always @(posedge clk) begin
    logic [15:0] r;
    logic        e;
    i_alu_done <= 1'b0;
    if (alu_cnt == 1) begin
      alu_ref(alu_op_q, alu_a_q, alu_b_q, r, e);
      i_alu_done   <= 1'b1;
      i_alu_result <= r;
      i_alu_error  <= e;
      done_cnt     <= done_cnt + 1;
    end
    if (alu_cnt != 0) alu_cnt <= alu_cnt - 1;
    if (rst_n && o_alu_start) begin
      got_start.push_back('{op: o_alu_op, a: o_alu_a, b: o_alu_b});
      alu_op_q <= o_alu_op;
      alu_a_q  <= o_alu_a;
      alu_b_q  <= o_alu_b;
      alu_cnt  <= 3;
    end
    if (rst_n && o_disp_valid && i_disp_ready)
      got_disp.push_back('{data: o_disp_data, err: o_disp_error});
  end

  task automatic tick();
    @(negedge clk);
    if (rnd_rdy) i_disp_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one key and hold it until the core takes it.
  task automatic send_key(input logic [4:0] k);
    bit acc = 1'b0;
    i_data  = k;
    i_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (o_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      tick();
    end
    tick();
    i_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL key_accept: key %h not taken within budget", k);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (o_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_wait: core still busy, ready=%b", o_ready);
    end
  endtask

  // Behavioural calculator: mode 0 entering A, 1 awaiting B, 2 entering B,
  // 3 showing result, 4 error.
  int          m_mode, m_na, m_nb;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_op;

  task automatic m_push(input logic [15:0] d, input logic e);
    exp_disp.push_back('{data: d, err: e});
  endtask

  task automatic m_exec(input bit has_pend, input logic [1:0] pop);
    logic [15:0] res;
    logic        err;
    exp_start.push_back('{op: m_op, a: m_a, b: m_b});
    alu_ref(m_op, m_a, m_b, res, err);
    if (err) begin
      m_push(16'h0000, 1'b1);
      m_mode = 4;
    end else begin
      m_a  = res;
      m_na = 4;
      m_push(res, 1'b0);
      if (has_pend) begin m_op = pop; m_mode = 1; end
      else m_mode = 3;
    end
  endtask

  task automatic model_key(input logic [4:0] k);
    logic [15:0] d;
    d = {11'd0, k};
    if (k == KEY_AC) begin
      m_a = 16'h0; m_b = 16'h0; m_na = 0; m_nb = 0; m_op = 2'd0; m_mode = 0;
      m_push(16'h0000, 1'b0);
    end else if (k < 5'h10) begin
      if (m_mode == 0 && m_na < 4) begin
        m_a = m_a * 16'd16 + d; m_na++; m_push(m_a, 1'b0);
      end else if (m_mode == 1) begin
        m_b = d; m_nb = 1; m_mode = 2; m_push(m_b, 1'b0);
      end else if (m_mode == 2 && m_nb < 4) begin
        m_b = m_b * 16'd16 + d; m_nb++; m_push(m_b, 1'b0);
      end else if (m_mode == 3) begin
        m_a = d; m_na = 1; m_mode = 0; m_push(m_a, 1'b0);
      end
    end else if (k >= KEY_ADD && k <= KEY_DIV) begin
      logic [4:0] rel;
      rel = k - KEY_ADD;
      if (m_mode == 0 || m_mode == 1 || m_mode == 3) begin
        m_op = rel[1:0]; m_mode = 1; m_push(m_a, 1'b0);
      end else if (m_mode == 2) begin
        m_exec(1'b1, rel[1:0]);
      end
    end else if (k == KEY_EQ && m_mode == 2) begin
      m_exec(1'b0, 2'd0);
    end
  endtask

  typedef struct packed {
    logic [0:7][4:0] keys;
    logic [3:0]      n;
    logic [15:0]     last;
    logic            err;
    logic [3:0]      nd;
    logic [1:0]      ns;
    logic [1:0]      op;
    logic [15:0]     a;
    logic [15:0]     b;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{keys: {5'h01, 5'h02, KEY_ADD, 5'h03, KEY_EQ, PAD, PAD, PAD}, n: 4'd5,
               last: 16'h0015, err: 1'b0, nd: 4'd5, ns: 2'd1, op: 2'd0, a: 16'h0012, b: 16'h0003};
    tbl[1] = '{keys: {5'h05, KEY_MUL, 5'h03, KEY_SUB, 5'h02, KEY_EQ, PAD, PAD}, n: 4'd6,
               last: 16'h000D, err: 1'b0, nd: 4'd6, ns: 2'd2, op: 2'd2, a: 16'h0005, b: 16'h0003};
    tbl[2] = '{keys: {5'h08, KEY_DIV, 5'h00, KEY_EQ, 5'h04, PAD, PAD, PAD}, n: 4'd5,
               last: 16'h0000, err: 1'b1, nd: 4'd4, ns: 2'd1, op: 2'd3, a: 16'h0008, b: 16'h0000};
    tbl[3] = '{keys: {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h17, PAD, PAD}, n: 4'd6,
               last: 16'h1234, err: 1'b0, nd: 4'd4, ns: 2'd0, op: 2'd0, a: 16'h0000, b: 16'h0000};
    tbl[4] = '{keys: {5'h0F, 5'h0F, 5'h0F, KEY_SUB, 5'h01, KEY_EQ, PAD, PAD}, n: 4'd6,
               last: 16'h0FFE, err: 1'b0, nd: 4'd6, ns: 2'd1, op: 2'd1, a: 16'h0FFF, b: 16'h0001};
    tbl[5] = '{keys: {5'h03, KEY_ADD, 5'h04, KEY_EQ, 5'h07, PAD, PAD, PAD}, n: 4'd5,
               last: 16'h0007, err: 1'b0, nd: 4'd5, ns: 2'd1, op: 2'd0, a: 16'h0003, b: 16'h0004};
    tbl[6] = '{keys: {5'h0F, 5'h0F, 5'h0F, 5'h0F, KEY_MUL, 5'h02, KEY_EQ, PAD}, n: 4'd7,
               last: 16'hFFFE, err: 1'b0, nd: 4'd7, ns: 2'd1, op: 2'd2, a: 16'hFFFF, b: 16'h0002};
    tbl[7] = '{keys: {5'h04, KEY_EQ, KEY_ADD, KEY_SUB, 5'h02, KEY_EQ, PAD, PAD}, n: 4'd6,
               last: 16'h0002, err: 1'b0, nd: 4'd5, ns: 2'd1, op: 2'd1, a: 16'h0004, b: 16'h0002};
    tbl[8] = '{keys: {5'h01, KEY_SUB, 5'h02, KEY_EQ, PAD, PAD, PAD, PAD}, n: 4'd4,
               last: 16'hFFFF, err: 1'b0, nd: 4'd4, ns: 2'd1, op: 2'd1, a: 16'h0001, b: 16'h0002};

    // Reset values, both during and just after reset.
    repeat (3) tick();
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_disp_valid", {31'd0, o_disp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_start", {31'd0, o_alu_start}, 32'd0);
    check("post_rst_disp", {15'd0, o_disp_data, o_disp_error}, 32'd0);
    check("post_rst_ready", {31'd0, o_ready}, 32'd1);

    // Table of fixed key sequences, each preceded by AC.
    for (int t = 0; t < 9; t++) begin
      send_key(KEY_AC);
      wait_idle();
      check($sformatf("v%0d_ac_disp", t), {15'd0, got_disp[$].data, got_disp[$].err}, 32'd0);
      got_disp.delete();
      got_start.delete();
      for (int j = 0; j < int'(tbl[t].n); j++) begin
        send_key(tbl[t].keys[j]);
        wait_idle();
      end
      check($sformatf("v%0d_ndisp", t), got_disp.size(), {28'd0, tbl[t].nd});
      check($sformatf("v%0d_nstart", t), got_start.size(), {30'd0, tbl[t].ns});
      if (got_disp.size() > 0)
        check($sformatf("v%0d_last", t), {15'd0, got_disp[$].data, got_disp[$].err},
              {15'd0, tbl[t].last, tbl[t].err});
      if (tbl[t].ns != 2'd0 && got_start.size() > 0)
        check($sformatf("v%0d_start0", t), {got_start[0].op, got_start[0].a[14:0], got_start[0].b},
              {tbl[t].op, tbl[t].a[14:0], tbl[t].b});
    end

    // Display backpressure holds off the next key without dropping it.
    send_key(KEY_AC);
    wait_idle();
    got_disp.delete();
    i_disp_ready = 1'b0;
    send_key(5'h07);
    i_data  = 5'h08;
    i_valid = 1'b1;
    repeat (5) tick();
    check("bp_ready_low", {31'd0, o_ready}, 32'd0);
    check("bp_valid_held", {15'd0, o_disp_valid, o_disp_data}, {15'd0, 1'b1, 16'h0007});
    check("bp_no_xfer", got_disp.size(), 32'd0);
    i_disp_ready = 1'b1;
    send_key(5'h08);
    wait_idle();
    check("bp_count", got_disp.size(), 32'd2);
    if (got_disp.size() == 2) begin
      check("bp_first", {16'd0, got_disp[0].data}, 32'h0007);
      check("bp_second", {16'd0, got_disp[1].data}, 32'h0078);
    end

    // Reset in the middle of an ALU operation.
    send_key(KEY_AC);
    wait_idle();
    send_key(5'h06); wait_idle();
    send_key(KEY_ADD); wait_idle();
    send_key(5'h01); wait_idle();
    send_key(KEY_EQ);
    tick();
    check("exec_busy", {31'd0, o_ready}, 32'd0);
    begin
      int sz, dc;
      rst_n = 1'b0;
      #1;
      check("rst_exec_outs", {o_alu_start, o_disp_valid, o_disp_error, o_ready, o_alu_a[13:0], o_alu_b},
            {4'b0001, 14'd0, 16'd0});
      sz = got_disp.size();
      dc = done_cnt;
      tick(); tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("late_done_seen", {31'd0, done_cnt > dc}, 32'd1);
      check("late_done_ignored", got_disp.size(), sz);
      send_key(5'h09);
      wait_idle();
      check("after_rst_count", got_disp.size(), sz + 1);
      check("after_rst_disp", {15'd0, got_disp[$].data, got_disp[$].err}, {15'd0, 16'h0009, 1'b0});
    end

    // Random keys with random display backpressure against the model.
    send_key(KEY_AC);
    wait_idle();
    got_disp.delete();
    got_start.delete();
    exp_disp.delete();
    exp_start.delete();
    model_key(KEY_AC);
    exp_disp.delete();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [4:0] k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = 5'($urandom_range(0, 15));
      else if (r < 80) k = 5'($urandom_range(17, 20));
      else if (r < 90) k = KEY_EQ;
      else if (r < 94) k = KEY_AC;
      else             k = 5'($urandom_range(22, 31));
      model_key(k);
      send_key(k);
    end
    rnd_rdy = 1'b0;
    i_disp_ready = 1'b1;
    wait_idle();
    check("rnd_disp_count", got_disp.size(), exp_disp.size());
    check("rnd_start_count", got_start.size(), exp_start.size());
    for (int i = 0; i < got_disp.size() && i < exp_disp.size(); i++)
      check($sformatf("rnd_disp%0d", i), {15'd0, got_disp[i].data, got_disp[i].err},
            {15'd0, exp_disp[i].data, exp_disp[i].err});
    for (int i = 0; i < got_start.size() && i < exp_start.size(); i++)
      check($sformatf("rnd_start%0d", i), {got_start[i].op, got_start[i].a[13:0], got_start[i].b},
            {exp_start[i].op, exp_start[i].a[13:0], exp_start[i].b});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
